// File: rtl/demux_pkg.sv
// Shared constants for the buffered 1-to-8 demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int SEL_W_DEF = 3;
  localparam int NCH       = 1 << SEL_W_DEF;
  localparam int OCC_W     = SEL_W_DEF + 1;
endpackage

// File: rtl/demux_slot.sv
// One-entry holding register (valid + data) for a single demux channel.
// Latency: a load on edge N is visible on o_valid/o_data after edge N.
// Backpressure: load wins over drain, so drain+load in one cycle refills with no bubble.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_drain,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Capture a new word on load; otherwise empty the slot when the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/demux1_8_32_buf.sv
// Buffered 1-to-8 demux: one producer word routed by in_sel into per-channel holding registers.
// Latency: accepted word visible on out_valid/out_data one edge later; occupancy tracks the same edge.
// Backpressure: in_ready drops only when the target channel is full and its consumer is stalled.
// Optional: DEMUX_BCAST_EN adds in_bcast, loading all channels at once when all can accept.
module demux1_8_32_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SEL_W-1:0]              in_sel,
  input  logic [WIDTH-1:0]              in_data,
`ifdef DEMUX_BCAST_EN
  input  logic                          in_bcast,
`endif
  output logic [(1<<SEL_W)-1:0]         out_valid,
  input  logic [(1<<SEL_W)-1:0]         out_ready,
  output logic [(1<<SEL_W)*WIDTH-1:0]   out_data,
  output logic [SEL_W:0]                occupancy
);

  localparam int NCH_L = 1 << SEL_W;
  localparam int OCC_L = SEL_W + 1;

  logic [NCH_L-1:0] w_valid;
  logic [NCH_L-1:0] w_load;
  logic [NCH_L-1:0] w_drain;
  logic [NCH_L-1:0] w_valid_nxt;
  logic             w_sel_free;
  logic             w_bcast;
  logic             w_acc;
  logic [OCC_L-1:0] w_occ_nxt;
  logic [OCC_L-1:0] r_occ;
`ifdef DEMUX_BCAST_EN
  logic             w_all_free;
`endif

  // Producer handshake: target channel can take a word if empty or draining this cycle.
  always_comb begin
    w_sel_free = !w_valid[in_sel] | out_ready[in_sel];
    w_bcast    = 1'b0;
`ifdef DEMUX_BCAST_EN
    w_bcast    = in_valid & in_bcast;
    w_all_free = &(~w_valid | out_ready);
    in_ready   = w_bcast ? w_all_free : w_sel_free;
`else
    in_ready   = w_sel_free;
`endif
  end

  assign w_acc   = in_valid & in_ready;
  assign w_drain = w_valid & out_ready;

  genvar g;
  generate
    for (g = 0; g < NCH_L; g++) begin : g_slot
      assign w_load[g]      = w_acc & (w_bcast | (in_sel == SEL_W'(g)));
      assign w_valid_nxt[g] = w_load[g] | (w_valid[g] & ~out_ready[g]);

      demux_slot #(.WIDTH(WIDTH)) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load[g]),
        .i_drain (w_drain[g]),
        .i_data  (in_data),
        .o_valid (w_valid[g]),
        .o_data  (out_data[g*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // Popcount of the post-edge valid vector so occupancy moves on the same edge as the slots.
  always_comb begin
    w_occ_nxt = '0;
    for (int k = 0; k < NCH_L; k++) begin
      w_occ_nxt = w_occ_nxt + OCC_L'(w_valid_nxt[k]);
    end
  end

  // Registered occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      r_occ <= w_occ_nxt;
    end
  end

  assign out_valid = w_valid;
  assign occupancy = r_occ;

endmodule
